// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and types for the NPC core pipeline stages
package npc_pkg;
  localparam int XLEN = 32;
  localparam int CAUSE_ECALL_M = 11;
  localparam logic [1:0] CSR_MCAUSE = 2'd0;
  localparam logic [1:0] CSR_MEPC = 2'd1;
  localparam logic [1:0] CSR_MSTATUS = 2'd2;
  localparam logic [1:0] CSR_MTVEC = 2'd3;
  typedef enum logic [2:0] {
    WBU_IDLE,
    WBU_WB,
    WBU_TRAP_EPC,
    WBU_TRAP_CAUSE,
    WBU_RESP
  } wbu_state_e;
endpackage

// File: rtl/npc_wbu.sv
// npc_wbu: writeback/commit stage driving GPR/CSR writes, ecall trap entry and next-PC handoff
module npc_wbu
  import npc_pkg::*;
#(
  parameter int XLEN = npc_pkg::XLEN,
  parameter int CAUSE_ECALL = CAUSE_ECALL_M,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_dnpc,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_wen,
  input  logic [XLEN-1:0]  in_rd_data,
  input  logic             in_csr_wen,
  input  logic [1:0]       in_csr_idx,
  input  logic [XLEN-1:0]  in_csr_data,
  input  logic             in_ecall,
  input  logic             in_mret,
  input  logic [XLEN-1:0]  mepc_in,
  input  logic [XLEN-1:0]  mtvec_in,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  wd,
  output logic             rwEnable,
  output logic [1:0]       csr_rd,
  output logic [XLEN-1:0]  csr_wd,
  output logic             csrwEnable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_npc,
  output logic [CNT_W-1:0] retire_cnt
);
  wbu_state_e state, state_nxt;
  logic [XLEN-1:0] p_pc, p_dnpc, p_rd_data, p_csr_data;
  logic [4:0] p_rd;
  logic [1:0] p_csr_idx;
  logic p_rd_wen, p_csr_wen, p_mret;
  wire accept = (state == WBU_IDLE) && in_valid;
  always_comb begin
    state_nxt = state;
    case (state)
      WBU_IDLE:       state_nxt = in_valid ? (in_ecall ? WBU_TRAP_EPC : WBU_WB) : WBU_IDLE;
      WBU_WB:         state_nxt = WBU_RESP;
      WBU_TRAP_EPC:   state_nxt = WBU_TRAP_CAUSE;
      WBU_TRAP_CAUSE: state_nxt = WBU_RESP;
      WBU_RESP:       state_nxt = out_ready ? WBU_IDLE : WBU_RESP;
      default:        state_nxt = WBU_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WBU_IDLE;
      p_pc <= '0;
      p_dnpc <= '0;
      p_rd <= '0;
      p_rd_wen <= 1'b0;
      p_rd_data <= '0;
      p_csr_wen <= 1'b0;
      p_csr_idx <= '0;
      p_csr_data <= '0;
      p_mret <= 1'b0;
      out_npc <= '0;
      retire_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        p_pc <= in_pc;
        p_dnpc <= in_dnpc;
        p_rd <= in_rd;
        p_rd_wen <= in_rd_wen;
        p_rd_data <= in_rd_data;
        p_csr_wen <= in_csr_wen;
        p_csr_idx <= in_csr_idx;
        p_csr_data <= in_csr_data;
        p_mret <= in_mret;
      end
      if (state == WBU_WB) out_npc <= p_mret ? mepc_in : p_dnpc;
      if (state == WBU_TRAP_CAUSE) out_npc <= mtvec_in;
      if (state == WBU_RESP && out_ready) retire_cnt <= retire_cnt + 1'b1;
    end
  end
  // Trap states override the CSR port with the mepc/mcause writes; x0 is never written
  always_comb begin
    in_ready = state == WBU_IDLE;
    out_valid = state == WBU_RESP;
    rd = p_rd;
    wd = p_rd_data;
    rwEnable = (state == WBU_WB) && p_rd_wen && (p_rd != 5'd0);
    csrwEnable = ((state == WBU_WB) && p_csr_wen && !p_mret) ||
                 (state == WBU_TRAP_EPC) || (state == WBU_TRAP_CAUSE);
    csr_rd = (state == WBU_TRAP_EPC) ? CSR_MEPC :
             (state == WBU_TRAP_CAUSE) ? CSR_MCAUSE : p_csr_idx;
    csr_wd = (state == WBU_TRAP_EPC) ? p_pc :
             (state == WBU_TRAP_CAUSE) ? XLEN'(CAUSE_ECALL) : p_csr_data;
  end
endmodule

// File: tb/tb_npc_wbu.sv
// tb_npc_wbu: directed self-checking bench for the writeback stage
module tb_npc_wbu;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_dnpc = '0, in_rd_data = '0, in_csr_data = '0;
  logic [4:0] in_rd = '0;
  logic in_rd_wen = 1'b0, in_csr_wen = 1'b0, in_ecall = 1'b0, in_mret = 1'b0;
  logic [1:0] in_csr_idx = '0;
  logic [31:0] mepc_in = '0, mtvec_in = '0;
  logic [4:0] rd;
  logic [31:0] wd, csr_wd, out_npc;
  logic rwEnable, csrwEnable, out_valid;
  logic [1:0] csr_rd;
  logic out_ready = 1'b1;
  logic [63:0] retire_cnt;
  int total = 0, passed = 0;

  npc_wbu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_dnpc(in_dnpc), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_rd_data(in_rd_data), .in_csr_wen(in_csr_wen), .in_csr_idx(in_csr_idx),
    .in_csr_data(in_csr_data), .in_ecall(in_ecall), .in_mret(in_mret),
    .mepc_in(mepc_in), .mtvec_in(mtvec_in), .rd(rd), .wd(wd), .rwEnable(rwEnable),
    .csr_rd(csr_rd), .csr_wd(csr_wd), .csrwEnable(csrwEnable),
    .out_valid(out_valid), .out_ready(out_ready), .out_npc(out_npc),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] dnpc, input logic [4:0] r,
                       input logic rwen, input logic [31:0] rdata, input logic cwen,
                       input logic [1:0] cidx, input logic [31:0] cdata,
                       input logic ec, input logic mr);
    in_pc = pc; in_dnpc = dnpc; in_rd = r; in_rd_wen = rwen; in_rd_data = rdata;
    in_csr_wen = cwen; in_csr_idx = cidx; in_csr_data = cdata; in_ecall = ec; in_mret = mr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rwEnable", rwEnable, 0);
    chk("rst_csrwEnable", csrwEnable, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_npc", out_npc, 0);
    chk("rst_rd_wd", {rd, wd}, 0);
    chk("rst_csr", {csr_rd, csr_wd}, 0);
    chk("rst_retire", retire_cnt, 0);
    rst = 1'b1;
    tick();
    // addi x5
    issue(32'h80000000, 32'h80000004, 5'd5, 1, 32'h1234, 0, 2'd0, 0, 0, 0);
    chk("addi_rwEnable", rwEnable, 1);
    chk("addi_rd", rd, 5);
    chk("addi_wd", wd, 32'h1234);
    chk("addi_csrwEnable", csrwEnable, 0);
    chk("addi_wb_in_ready", in_ready, 0);
    chk("addi_wb_out_valid", out_valid, 0);
    tick();
    chk("addi_out_valid", out_valid, 1);
    chk("addi_out_npc", out_npc, 32'h80000004);
    chk("addi_resp_rwEnable", rwEnable, 0);
    tick();
    chk("addi_retire", retire_cnt, 1);
    chk("addi_in_ready", in_ready, 1);
    // write to x0 is suppressed
    issue(32'h80000004, 32'h80000008, 5'd0, 1, 32'hdead, 0, 2'd0, 0, 0, 0);
    chk("x0_wb_rwEnable", rwEnable, 0);
    tick();
    chk("x0_resp_rwEnable", rwEnable, 0);
    chk("x0_out_npc", out_npc, 32'h80000008);
    tick();
    chk("x0_retire", retire_cnt, 2);
    // csrrw mtvec, x6
    issue(32'h80000008, 32'h8000000c, 5'd6, 1, 32'h0, 1, 2'd3, 32'h80001000, 0, 0);
    chk("csrrw_rwEnable", rwEnable, 1);
    chk("csrrw_rd_wd", {rd, wd}, {5'd6, 32'h0});
    chk("csrrw_csrwEnable", csrwEnable, 1);
    chk("csrrw_csr_rd", csr_rd, 3);
    chk("csrrw_csr_wd", csr_wd, 32'h80001000);
    tick();
    chk("csrrw_resp_csrwEnable", csrwEnable, 0);
    tick();
    chk("csrrw_retire", retire_cnt, 3);
    // ecall: rd_wen/csr_wen/mret ignored
    mtvec_in = 32'h80001000;
    issue(32'h80000010, 32'h80000014, 5'd7, 1, 32'h77, 1, 2'd2, 32'h5, 1, 1);
    chk("ecall_epc_en", csrwEnable, 1);
    chk("ecall_epc_idx", csr_rd, 1);
    chk("ecall_epc_wd", csr_wd, 32'h80000010);
    chk("ecall_epc_rwEnable", rwEnable, 0);
    tick();
    chk("ecall_cause_en", csrwEnable, 1);
    chk("ecall_cause_idx", csr_rd, 0);
    chk("ecall_cause_wd", csr_wd, 11);
    chk("ecall_cause_rwEnable", rwEnable, 0);
    chk("ecall_cause_out_valid", out_valid, 0);
    tick();
    chk("ecall_out_valid", out_valid, 1);
    chk("ecall_out_npc", out_npc, 32'h80001000);
    chk("ecall_resp_en", {rwEnable, csrwEnable}, 0);
    tick();
    chk("ecall_retire", retire_cnt, 4);
    // mret with backpressure
    mepc_in = 32'h80000014;
    issue(32'h80001000, 32'h80001004, 5'd0, 0, 0, 1, 2'd2, 32'h88, 0, 1);
    out_ready = 1'b0;
    chk("mret_csrwEnable", csrwEnable, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_npc", out_npc, 32'h80000014);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_retire", retire_cnt, 4);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("mret_retire", retire_cnt, 5);
    chk("mret_in_ready", in_ready, 1);
    // async reset during trap entry
    issue(32'h80000020, 32'h80000024, 5'd0, 0, 0, 0, 2'd0, 0, 1, 0);
    chk("rstmid_epc_en", csrwEnable, 1);
    rst = 1'b0;
    #1;
    chk("rstmid_csrwEnable", csrwEnable, 0);
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_retire", retire_cnt, 0);
    rst = 1'b1;
    tick();
    chk("rstmid_no_cause", csrwEnable, 0);
    chk("rstmid_no_valid", out_valid, 0);
    issue(32'h80000030, 32'h80000034, 5'd3, 1, 32'h55, 0, 2'd0, 0, 0, 0);
    chk("post_rwEnable", rwEnable, 1);
    chk("post_rd_wd", {rd, wd}, {5'd3, 32'h55});
    tick();
    chk("post_out_npc", out_npc, 32'h80000034);
    tick();
    chk("post_retire", retire_cnt, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/npc_wbu.md
Name: npc_wbu

Overview:
- Writeback/commit stage of the NPC core; the initiator side of the GPR/CSR register-file write interface.
- Accepts one executed instruction per valid/ready handshake from EXU and drives the register-file write port (GPR and CSR).
- Sequences ecall trap entry (mepc, then mcause) over the single CSR write port; resolves mret/ecall/normal next PC.
- Hands the next PC to IFU with a valid/ready handshake; counts retired instructions.

Parameters:
XLEN, 32, datapath and PC width
CAUSE_ECALL, 11, value written to mcause on ecall (M-mode environment call)
CNT_W, 64, retire counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  EXU result valid
in_ready  out  1  WBU can accept
in_pc  in  XLEN  PC of instruction
in_dnpc  in  XLEN  sequential/branch next PC from EXU
in_rd  in  5  GPR destination index
in_rd_wen  in  1  GPR write request
in_rd_data  in  XLEN  GPR write data
in_csr_wen  in  1  CSR write request
in_csr_idx  in  2  CSR index: 0 mcause, 1 mepc, 2 mstatus, 3 mtvec
in_csr_data  in  XLEN  CSR write data
in_ecall  in  1  instruction is ecall
in_mret  in  1  instruction is mret
mepc_in  in  XLEN  current mepc from register file
mtvec_in  in  XLEN  current mtvec from register file
rd  out  5  GPR write index
wd  out  XLEN  GPR write data
rwEnable  out  1  GPR write enable
csr_rd  out  2  CSR write index
csr_wd  out  XLEN  CSR write data
csrwEnable  out  1  CSR write enable
out_valid  out  1  next PC valid to IFU
out_ready  in  1  IFU accepts next PC
out_npc  out  XLEN  next PC
retire_cnt  out  CNT_W  retired instruction count

Behaviour:
- States: IDLE, WB, TRAP_EPC, TRAP_CAUSE, RESP. Reset state IDLE.
- Reset values: in_ready 1, rwEnable 0, csrwEnable 0, out_valid 0, out_npc 0, rd 0, wd 0, csr_rd 0, csr_wd 0, retire_cnt 0. rst low mid-operation returns to IDLE immediately (async), drops all enables, discards the latched instruction, clears retire_cnt.
- in_ready = (state == IDLE). All outputs depend only on state and payload registers; no combinational in_* -> output path.
- IDLE: on in_valid, latch all in_* fields. If in_ecall -> TRAP_EPC, else -> WB. ecall takes priority over mret/rd_wen/csr_wen, which are ignored for an ecall.
- WB (1 cycle): rwEnable = rd_wen && rd != 0; rd/wd from payload. csrwEnable = csr_wen && !mret; csr_rd/csr_wd from payload. GPR and CSR writes occur in the same cycle (csrrw). Register out_npc = mret ? mepc_in (sampled this cycle) : dnpc -> RESP.
- TRAP_EPC (1 cycle): csrwEnable 1, csr_rd 1, csr_wd = pc; rwEnable 0 -> TRAP_CAUSE.
- TRAP_CAUSE (1 cycle): csrwEnable 1, csr_rd 0, csr_wd = CAUSE_ECALL; register out_npc = mtvec_in -> RESP.
- RESP: out_valid 1, out_npc stable; no writes. When out_valid && out_ready: retire_cnt += 1 (wraps at 2^CNT_W), -> IDLE.
- Latency: accept edge to out_valid is 2 cycles normal, 3 cycles ecall. Throughput is one instruction per (latency + 1) cycles minimum.
- out_ready held low: stay in RESP indefinitely, outputs stable, in_ready 0.
- Enables are single-cycle pulses; no write is repeated.

Decomposition:
- Shared package npc_pkg: CSR index constants (CSR_MCAUSE=0, CSR_MEPC=1, CSR_MSTATUS=2, CSR_MTVEC=3), wbu state enum, CAUSE_ECALL_M=11, XLEN.
- No sub-module needed. FSM, payload register and retire counter are inline.

Test Plan:
- addi: rd=5, rd_wen=1, rd_data=0x1234, dnpc=0x80000004 -> next cycle rwEnable=1, rd=5, wd=0x1234; following cycle out_valid=1, out_npc=0x80000004; handshake -> retire_cnt=1.
- rd=0, rd_wen=1, rd_data=0xdead -> rwEnable stays 0 in all cycles; out_npc = dnpc.
- csrrw: csr_wen=1, csr_idx=3, csr_data=0x80001000, rd=6, rd_data=0x0 -> in the single WB cycle, rwEnable=1 and csrwEnable=1 with csr_rd=3, csr_wd=0x80001000.
- ecall: pc=0x80000010, mtvec_in=0x80001000 -> cycle 1: csr_rd=1, csr_wd=0x80000010; cycle 2: csr_rd=0, csr_wd=11; then out_npc=0x80001000; rwEnable never asserted.
- mret: mepc_in=0x80000014, csr_wen=1 -> csrwEnable stays 0; out_npc=0x80000014.
- Backpressure/reset: out_ready low for 5 cycles -> out_valid and out_npc stable, in_ready 0, retire_cnt unchanged. rst pulsed low during TRAP_EPC -> csrwEnable 0 immediately, state IDLE, no mcause write; next instruction is accepted normally.
